dff: RTL and testbench



---
 rtl/dsp_pkg.sv | 16 +
 rtl/dff.sv | 69 ++++++
 tb/tb_dff.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/dsp_pkg.sv
// Shared constants for the DSP48E1-style datapath: operand widths and register-stage limits.
package dsp_pkg;

  localparam int A_WIDTH = 30;
  localparam int B_WIDTH = 18;
  localparam int C_WIDTH = 48;
  localparam int D_WIDTH = 25;
  localparam int P_WIDTH = 48;

  localparam int MAX_REG_STAGES = 2;

  function automatic bit reg_stages_ok(input int n);
    return (n >= 0) && (n <= MAX_REG_STAGES);
  endfunction

endpackage

// File: rtl/dff.sv
// Purpose: width-generic 0/1/2-stage pipeline register with sync reset and clock enable; DFF_BYPASS_EN adds a bypass port.
// Latency: REG_STAGES enabled edges (0 = combinational pass-through; bypass=1 is also combinational).
// Backpressure: ce=0 freezes every stage together; the pipeline never bubbles and has no ready output.
module dff
  import dsp_pkg::*;
#(
  parameter int                      signal_width = 16,
  parameter int                      REG_STAGES   = 1,
  parameter logic [signal_width-1:0] RST_VALUE    = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
`ifdef DFF_BYPASS_EN
  input  logic                    bypass,
`endif
  input  logic [signal_width-1:0] in,
  output logic [signal_width-1:0] out
);

  logic [signal_width-1:0] reg_out;

  if (!reg_stages_ok(REG_STAGES)) begin : g_bad_stages
    $error("dff: REG_STAGES must be 0, 1 or 2");
  end

  if (signal_width < 1) begin : g_bad_width
    $error("dff: signal_width must be at least 1");
  end

  if (REG_STAGES == 0) begin : g_pass
    assign reg_out = in;
  end else begin : g_regs
    for (genvar i = 0; i < REG_STAGES; i++) begin : g_stage
      logic [signal_width-1:0] stage_src;
      logic [signal_width-1:0] stage_d;
      logic [signal_width-1:0] stage_q;

      if (i == 0) begin : g_first
        assign stage_src = in;
      end else begin : g_next
        assign stage_src = g_stage[i-1].stage_q;
      end

      // rst outranks ce so a reset edge flushes in-flight data regardless of enable.
      always_comb begin
        stage_d = stage_q;
        if (rst) begin
          stage_d = RST_VALUE;
        end else if (ce) begin
          stage_d = stage_src;
        end
      end

      always_ff @(posedge clk) begin
        stage_q <= stage_d;
      end
    end

    assign reg_out = g_stage[REG_STAGES-1].stage_q;
  end

`ifdef DFF_BYPASS_EN
  assign out = bypass ? in : reg_out;
`else
  assign out = reg_out;
`endif

endmodule

// File: tb/tb_dff.sv
// Self-checking bench for dff: directed vector table, hand-written corner sequences, and a randomized soak against a history model.
module tb_dff;

  localparam int              W        = 16;
  localparam logic [W-1:0]    RSTV_ALT = 16'hA5C3;

  logic         clk;
  logic         rst;
  logic         ce;
  logic [W-1:0] din;
  logic [W-1:0] out0;
  logic [W-1:0] out1;
  logic [W-1:0] out2;
  logic [W-1:0] outr;
`ifdef DFF_BYPASS_EN
  logic         bypass;
`endif

  int errors = 0;
  int checks = 0;

  // Accepted-value history: newest at the back. A k-stage pipe shows the k-th newest entry.
  logic [W-1:0] hist[$];

  typedef struct {
    logic         rst;
    logic         ce;
    logic [W-1:0] din;
    logic [W-1:0] e1;
    logic [W-1:0] e2;
  } vec_t;

  vec_t vecs[14];

  dff #(.signal_width(W), .REG_STAGES(0)) dut0 (
    .clk(clk), .rst(rst), .ce(ce),
`ifdef DFF_BYPASS_EN
    .bypass(1'b0),
`endif
    .in(din), .out(out0)
  );

  dff #(.signal_width(W), .REG_STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .ce(ce),
`ifdef DFF_BYPASS_EN
    .bypass(bypass),
`endif
    .in(din), .out(out1)
  );

  dff #(.signal_width(W), .REG_STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .ce(ce),
`ifdef DFF_BYPASS_EN
    .bypass(1'b0),
`endif
    .in(din), .out(out2)
  );

  dff #(.signal_width(W), .REG_STAGES(2), .RST_VALUE(RSTV_ALT)) dutr (
    .clk(clk), .rst(rst), .ce(ce),
`ifdef DFF_BYPASS_EN
    .bypass(1'b0),
`endif
    .in(din), .out(outr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive at negedge, take one rising edge, update the model, return at the next negedge.
  task automatic apply(input logic r, input logic c, input logic [W-1:0] d);
    rst = r;
    ce  = c;
    din = d;
    @(posedge clk);
    if (r) begin
      hist = '{16'h0000, 16'h0000};
    end else if (c) begin
      hist.push_back(d);
      if (hist.size() > 4) void'(hist.pop_front());
    end
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] prev;
    logic [W-1:0] pulse_val;
    int           changes;
    logic         r;
    logic         c;

    rst = 1'b0;
    ce  = 1'b0;
    din = '0;
`ifdef DFF_BYPASS_EN
    bypass = 1'b0;
`endif

    vecs[0]  = '{1'b1, 1'b0, 16'hABCD, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b1, 1'b1, 16'h1234, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 1'b0, 16'h5A5A, 16'h0000, 16'h0000};
    vecs[3]  = '{1'b0, 1'b1, 16'h5A5A, 16'h5A5A, 16'h0000};
    vecs[4]  = '{1'b0, 1'b0, 16'hFFFF, 16'h5A5A, 16'h0000};
    vecs[5]  = '{1'b0, 1'b1, 16'h00FF, 16'h00FF, 16'h5A5A};
    vecs[6]  = '{1'b1, 1'b1, 16'h7777, 16'h0000, 16'h0000};
    vecs[7]  = '{1'b0, 1'b0, 16'h7777, 16'h0000, 16'h0000};
    vecs[8]  = '{1'b0, 1'b1, 16'h1111, 16'h1111, 16'h0000};
    vecs[9]  = '{1'b0, 1'b1, 16'h0001, 16'h0001, 16'h1111};
    vecs[10] = '{1'b0, 1'b1, 16'h0002, 16'h0002, 16'h0001};
    vecs[11] = '{1'b0, 1'b1, 16'h0003, 16'h0003, 16'h0002};
    vecs[12] = '{1'b0, 1'b0, 16'h0004, 16'h0003, 16'h0002};
    vecs[13] = '{1'b0, 1'b1, 16'h8000, 16'h8000, 16'h0003};

    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      apply(vecs[i].rst, vecs[i].ce, vecs[i].din);
      chk($sformatf("vec%0d_stage1", i), out1, vecs[i].e1);
      chk($sformatf("vec%0d_stage2", i), out2, vecs[i].e2);
      if (vecs[i].rst) chk($sformatf("vec%0d_rst_value", i), outr, RSTV_ALT);
    end

    // Single-cycle ce pulse: out must change exactly once.
    changes   = 0;
    prev      = out1;
    pulse_val = 16'hCAFE;
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, (i == 2), (i == 2) ? pulse_val : 16'h9999);
      if (out1 !== prev) changes++;
      prev = out1;
    end
    chk("ce_pulse_changes", W'(changes), 16'd1);
    chk("ce_pulse_value", out1, pulse_val);

    // Pass-through with no clock edge between driving and sampling.
    din = 16'hBEEF;
    #1;
    chk("pass_beef", out0, 16'hBEEF);
    din = 16'h0F0F;
    #1;
    chk("pass_0f0f", out0, 16'h0F0F);

`ifdef DFF_BYPASS_EN
    bypass = 1'b1;
    din    = 16'hBEEF;
    #1;
    chk("bypass_comb", out1, 16'hBEEF);
    @(negedge clk);
    apply(1'b0, 1'b1, 16'h3C3C);
    chk("bypass_during_edge", out1, 16'h3C3C);
    din = 16'h4242;
    #1;
    chk("bypass_follow", out1, 16'h4242);
    bypass = 1'b0;
    #1;
    chk("bypass_off_stage", out1, 16'h3C3C);
    @(negedge clk);
`else
    @(negedge clk);
`endif

    apply(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 500; i++) begin
      r = ($urandom_range(0, 31) == 0);
      c = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       d = 16'h0000;
        1:       d = 16'hFFFF;
        2:       d = 16'h8000;
        default: d = W'($urandom);
      endcase
      apply(r, c, d);
      chk("soak_stage1", out1, hist[$]);
      chk("soak_stage2", out2, hist[$-1]);
      chk("soak_pass", out0, din);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
